ground_scroll_ctrl: RTL and testbench

- Game-level sequencer for the scrolling ground renderer.
- Owns the run/over state machine and the per-frame scroll position, speed ramp and distance score.
- The renderer consumes `ground_position`, `speed` and `game_status` combinationally and does no sequencing of its own.
- Sits between the VGA timing block (frame strobe), the player/collision logic (start, collision) and the ground/score display blocks.

---
 rtl/dino_pkg.sv | 23 ++
 rtl/ground_scroll_ctrl_edge_det.sv | 32 +++
 rtl/ground_scroll_ctrl.sv | 111 +++++++++++
 tb/tb_ground_scroll_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared game constants and state encoding for the ground/score renderers.
// Latency: n/a. Backpressure: n/a.
package dino_pkg;

  localparam int POS_W           = 10;
  localparam int PATTERN_LEN_DEF = 160;
  localparam int SPEED_INIT_DEF  = 1;
  localparam int SPEED_MAX_DEF   = 8;
  localparam int RAMP_FRAMES_DEF = 600;
  localparam int SCORE_W_DEF     = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_OVER = 2'd2;

  // A one-value counter still needs one bit of storage.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ground_scroll_ctrl_edge_det.sv
// Rise or fall pulse generator on a single-bit level, comb or registered output.
// Latency: 0 cycles (comb) or 1 cycle (REG_OUT). Backpressure: none.
module edge_det #(
  parameter bit   FALL    = 1'b0,
  parameter bit   REG_OUT = 1'b0,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_pulse
);

  logic r_sig_q;
  logic r_pulse;
  logic w_pulse;

  assign w_pulse = FALL ? (r_sig_q & ~i_sig) : (i_sig & ~r_sig_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig_q <= RST_VAL;
      r_pulse <= 1'b0;
    end else begin
      r_sig_q <= i_sig;
      r_pulse <= w_pulse;
    end
  end

  assign o_pulse = REG_OUT ? r_pulse : w_pulse;

endmodule

// File: rtl/ground_scroll_ctrl.sv
// Game sequencer: IDLE/RUN/OVER FSM, per-frame scroll position, speed ramp, score.
// Latency: fresh fall at edge N -> frame_tick in cycle N+1 -> position after N+2. Backpressure: none.
module ground_scroll_ctrl
  import dino_pkg::*;
#(
  parameter int PATTERN_LEN = PATTERN_LEN_DEF,
  parameter int SPEED_INIT  = SPEED_INIT_DEF,
  parameter int SPEED_MAX   = SPEED_MAX_DEF,
  parameter int RAMP_FRAMES = RAMP_FRAMES_DEF,
  parameter int SCORE_W     = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fresh,
  input  logic               start,
  input  logic               collision,
  output logic               game_status,
  output logic               game_over,
  output logic [POS_W-1:0]   ground_position,
  output logic [3:0]         speed,
  output logic [SCORE_W-1:0] score,
  output logic               frame_tick
);

  localparam int                 CNT_W    = cnt_width(RAMP_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RAMP_FRAMES - 1);
  localparam logic [3:0]         SPD_INIT = 4'(SPEED_INIT);
  localparam logic [3:0]         SPD_MAX  = 4'(SPEED_MAX);
  localparam logic [POS_W:0]     PLEN     = (POS_W + 1)'(PATTERN_LEN);

  state_t             r_state;
  logic [POS_W-1:0]   r_pos;
  logic [3:0]         r_speed;
  logic [SCORE_W-1:0] r_score;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_frame_tick;
  logic               w_start_rise;
  logic [POS_W:0]     w_sum;
  logic [POS_W-1:0]   w_pos_next;
  logic               w_score_sat;

  edge_det #(.FALL(1'b1), .REG_OUT(1'b1), .RST_VAL(1'b0)) u_fresh_fall (
    .clk     (clk),
    .rst     (rst),
    .i_sig   (fresh),
    .o_pulse (w_frame_tick)
  );

  // Reset value 1 keeps a start held through reset from launching a game.
  edge_det #(.FALL(1'b0), .REG_OUT(1'b0), .RST_VAL(1'b1)) u_start_rise (
    .clk     (clk),
    .rst     (rst),
    .i_sig   (start),
    .o_pulse (w_start_rise)
  );

  assign w_sum       = {1'b0, r_pos} + {{(POS_W - 3){1'b0}}, r_speed};
  assign w_pos_next  = (w_sum >= PLEN) ? POS_W'(w_sum - PLEN) : POS_W'(w_sum);
  assign w_score_sat = &r_score;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pos   <= '0;
      r_speed <= SPD_INIT;
      r_score <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (w_start_rise) begin
            r_state <= ST_RUN;
            r_pos   <= '0;
            r_speed <= SPD_INIT;
            r_score <= '0;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          // Collision wins over a same-cycle tick: the fatal frame is not counted.
          if (collision) begin
            r_state <= ST_OVER;
          end else if (w_frame_tick) begin
            r_pos <= w_pos_next;
            if (!w_score_sat) begin
              r_score <= r_score + 1'b1;
            end
            if (r_cnt == CNT_LAST) begin
              r_cnt <= '0;
              if (r_speed < SPD_MAX) begin
                r_speed <= r_speed + 4'd1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign game_status     = (r_state == ST_RUN);
  assign game_over       = (r_state == ST_OVER);
  assign ground_position = r_pos;
  assign speed           = r_speed;
  assign score           = r_score;
  assign frame_tick      = w_frame_tick;

endmodule

// File: tb/tb_ground_scroll_ctrl.sv
// Directed + random bench for ground_scroll_ctrl over three parameter sets,
// checked each cycle against an arithmetic reference model.
module tb_ground_scroll_ctrl;

  localparam int N    = 3;
  localparam int PLEN = 160;
  localparam int SI   = 1;
  localparam int P_RAMP [N] = '{600, 4, 1};
  localparam int P_MAX  [N] = '{8, 3, 8};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fresh = 1'b0;
  logic start = 1'b0;
  logic collision = 1'b0;

  logic        st_o   [N];
  logic        ov_o   [N];
  logic [9:0]  pos_o  [N];
  logic [3:0]  spd_o  [N];
  logic [15:0] sc_o   [N];
  logic        tick_o [N];

  int n_checks = 0;
  int n_errors = 0;
  int n_ticks  = 0;

  // Reference model: game state plus number of frames advanced in this game.
  int m_st [N];  // 0 idle, 1 run, 2 over
  int m_pos [N];
  int m_spd [N];
  int m_score [N];
  int m_k [N];
  logic m_tick, m_fresh_q, m_start_q;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    ground_scroll_ctrl #(
      .PATTERN_LEN (PLEN),
      .SPEED_INIT  (SI),
      .SPEED_MAX   (P_MAX[g]),
      .RAMP_FRAMES (P_RAMP[g]),
      .SCORE_W     (16)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .fresh           (fresh),
      .start           (start),
      .collision       (collision),
      .game_status     (st_o[g]),
      .game_over       (ov_o[g]),
      .ground_position (pos_o[g]),
      .speed           (spd_o[g]),
      .score           (sc_o[g]),
      .frame_tick      (tick_o[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_pos[i] = 0; m_spd[i] = SI; m_score[i] = 0; m_k[i] = 0;
    end
    m_tick = 1'b0; m_fresh_q = 1'b0; m_start_q = 1'b1;
  endtask

  task automatic model_edge();
    logic srise;
    srise = start & ~m_start_q;
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == 1) begin
        if (collision) m_st[i] = 2;
        else if (m_tick) begin
          m_pos[i]   = (m_pos[i] + m_spd[i]) % PLEN;
          m_k[i]     = m_k[i] + 1;
          m_score[i] = (m_k[i] > 65535) ? 65535 : m_k[i];
          m_spd[i]   = SI + m_k[i] / P_RAMP[i];
          if (m_spd[i] > P_MAX[i]) m_spd[i] = P_MAX[i];
        end
      end else if (srise) begin
        m_st[i] = 1; m_pos[i] = 0; m_spd[i] = SI; m_score[i] = 0; m_k[i] = 0;
      end
    end
    m_tick    = m_fresh_q & ~fresh;
    m_fresh_q = fresh;
    m_start_q = start;
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("status%0d", i), 32'(st_o[i]), 32'(m_st[i] == 1));
      chk($sformatf("over%0d", i),   32'(ov_o[i]), 32'(m_st[i] == 2));
      chk($sformatf("pos%0d", i),    32'(pos_o[i]), m_pos[i]);
      chk($sformatf("pos_range%0d", i), 32'(pos_o[i] < PLEN), 1);
      chk($sformatf("speed%0d", i),  32'(spd_o[i]), m_spd[i]);
      chk($sformatf("score%0d", i),  32'(sc_o[i]), m_score[i]);
      chk($sformatf("tick%0d", i),   32'(tick_o[i]), 32'(m_tick));
    end
    if (tick_o[0] === 1'b1) n_ticks++;
  endtask

  task automatic step(input logic f, input logic s, input logic c);
    fresh = f; start = s; collision = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic frame(input logic s);
    step(1'b1, s, 1'b0);
    step(1'b1, s, 1'b0);
    step(1'b0, s, 1'b0);
    step(1'b0, s, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    model_reset();
    check_all();
    rst = 1'b0;

    // Start, then three frames at speed 1
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("t1_running", 32'(st_o[0]), 1);
    n_ticks = 0;
    for (int f = 0; f < 3; f++) frame(1'b0);
    chk("t1_pos", 32'(pos_o[0]), 3);
    chk("t1_score", 32'(sc_o[0]), 3);
    chk("t1_ticks", n_ticks, 3);

    // Ramp: every 4 frames on instance 1, capped at 3
    for (int f = 4; f <= 12; f++) begin
      frame(1'b0);
      chk($sformatf("t3_speed_f%0d", f), 32'(spd_o[1]), (1 + f / 4 > 3) ? 3 : 1 + f / 4);
    end
    chk("t3_score", 32'(sc_o[1]), 12);
    chk("t3_speed0", 32'(spd_o[0]), 1);

    // Wrap sweep: instance 2 runs at speed 8 and wraps repeatedly
    for (int f = 0; f < 30; f++) frame(1'b0);
    chk("t2_speed_max", 32'(spd_o[2]), 8);
    chk("t2_pos", 32'(pos_o[2]), (36 + 8 * 34) % PLEN);

    // Collision on the tick cycle; start already held before OVER
    chk("t4_pre_pos", 32'(pos_o[0]), 42);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("t4_tick_now", 32'(tick_o[0]), 1);
    step(1'b0, 1'b1, 1'b1);
    chk("t4_over", 32'(ov_o[0]), 1);
    chk("t4_pos_frozen", 32'(pos_o[0]), 42);
    chk("t4_score_frozen", 32'(sc_o[0]), 42);
    for (int f = 0; f < 2; f++) frame(1'b1);
    chk("t5_no_restart", 32'(ov_o[0]), 1);
    chk("t5_pos_still", 32'(pos_o[0]), 42);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("t5_restart", 32'(st_o[0]), 1);
    chk("t5_pos0", 32'(pos_o[0]), 0);
    chk("t5_speed1", 32'(spd_o[0]), 1);
    chk("t5_score0", 32'(sc_o[0]), 0);

    // Random phase
    for (int c = 0; c < 1500; c++) begin
      step(($urandom_range(0, 2) == 0) ? ~fresh : fresh,
           ($urandom_range(0, 30) == 0) ? ~start : start,
           ($urandom_range(0, 60) == 0));
    end

    // Async reset mid-cycle during RUN, start held through release
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int f = 0; f < 6; f++) frame(1'b1);
    chk("t6_running", 32'(st_o[0]), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_status", 32'(st_o[0]), 0);
    chk("t6_pos", 32'(pos_o[0]), 0);
    chk("t6_pos1", 32'(pos_o[1]), 0);
    chk("t6_speed1", 32'(spd_o[1]), 1);
    chk("t6_score", 32'(sc_o[0]), 0);
    chk("t6_tick", 32'(tick_o[0]), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0);
    chk("t6_no_start", 32'(st_o[0]), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
